mem_read_port: RTL and testbench
================================

Name: mem_read_port

Overview:
- Per-agent read front-end that sits directly upstream of the multi-port RAM top.
- Converts a valid/ready read-request stream into the RAM's rden/rdaddr strobe.
- Tracks the fixed RAM read latency and captures rddata plus the 2-bit rdcollision status into a response FIFO.
- Uses credit-based flow control, so responses are never lost when the consumer back-pressures. One instance per read agent.

Parameters:
- ADDR_WIDTH, 8, request/RAM address width in bits.
- DATA_WIDTH, 32, RAM data width in bits.
- RD_LATENCY, 1, cycles from the rden sampling edge to rddata/rdcollision valid at the RAM output. Legal range ≥1.
- FIFO_DEPTH, 4, response FIFO entries. Must be a power of two and ≥ RD_LATENCY+3 for full throughput; any value ≥1 is functionally correct.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- req_valid  in  1  read request valid
- req_ready  out  1  request accepted when high with req_valid
- req_addr  in  ADDR_WIDTH  read address
- rden  out  1  RAM read enable
- rdaddr  out  ADDR_WIDTH  RAM read address
- rddata  in  DATA_WIDTH  RAM read data
- rdcollision  in  2  RAM read collision flags, aligned with rddata
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_data  out  DATA_WIDTH  response data
- rsp_collision  out  2  response collision flags
- credits  out  $clog2(FIFO_DEPTH)+1  free credits, for debug/status

Behaviour:
- Clock and reset: one clock, aclk. Reset aresetn is asynchronous, active-low.
- Reset values, all applied while aresetn is low:
  - rden=0, rdaddr=0, req_ready=0.
  - Latency pipe cleared.
  - FIFO empty: rsp_valid=0, rsp_data=0, rsp_collision=0.
  - credits=FIFO_DEPTH.
- Reset mid-operation discards all in-flight reads and queued responses.
- Request handshake: accept when req_valid && req_ready at a rising edge.
- Issue: on the accept edge, register rden<=1 and rdaddr<=req_addr. The RAM sees rden during the next cycle.
  - With no accept, rden<=0 and rdaddr holds its last value.
  - Back-to-back accepts give rden high on consecutive cycles.
- Latency tracking:
  - pipe is an RD_LATENCY-bit shift register, with pipe[0]<=rden and pipe[k]<=pipe[k-1].
  - When pipe[RD_LATENCY-1]==1, {rdcollision, rddata} is pushed into the FIFO at that edge.
  - For RD_LATENCY=1: rden is high in cycle C, data is valid in C+1, push occurs at the end of C+1, and rsp_valid is high from C+2.
- Credits:
  - Decrement by 1 on request accept.
  - Increment by 1 on response pop (rsp_valid && rsp_ready).
  - Both in the same cycle leaves credits unchanged.
  - The counter never goes below 0 or above FIFO_DEPTH.
- req_ready is a register: req_ready <= (credits_next != 0).
  - No combinational path from rsp_ready or req_valid to req_ready.
  - First cycle after reset release: req_ready=1.
- FIFO:
  - First-word fall-through; rsp_valid = !empty; rsp_data/rsp_collision are driven from the head entry.
  - Simultaneous push and pop is supported at any occupancy, including empty. When empty, the push is visible from the next cycle; there is no same-cycle bypass.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow is impossible by construction: in-flight reads plus FIFO occupancy ≤ FIFO_DEPTH - credits.
  - Assertion: a push while full is an error, flagged in simulation only.
- Ordering: responses are returned strictly in request order.
- rsp_data/rsp_collision are stable while rsp_valid && !rsp_ready.
- Throughput: with FIFO_DEPTH ≥ RD_LATENCY+3 and rsp_ready held at 1, one request is accepted every cycle indefinitely.

Test Plan:
1. Reset with req_valid=1 -> req_ready=0, rden=0, rsp_valid=0 and credits=4 throughout reset; req_ready=1 in the first cycle after release.
2. Single read: preload RAM[0x10]=0xDEADBEEF with RD_LATENCY=1; accept addr 0x10 at edge N -> rden=1/rdaddr=0x10 in cycle N+1; rsp_valid=1, rsp_data=0xDEADBEEF, rsp_collision=2'b00 in cycle N+3.
3. Streaming: with rsp_ready=1, issue 16 back-to-back reads of addresses 0..15 (RAM[i]=i*3) -> req_ready never drops; 16 responses arrive in order with data 0,3,...,45.
4. Back-pressure: with rsp_ready=0, issue requests until req_ready=0 -> exactly 4 accepted, credits=0, FIFO full. Raise rsp_ready for one cycle -> one pop, credits=1, req_ready=1 next cycle. All data is intact and in order.
5. Collision passthrough: hold rdcollision=2'b10 in the data-valid cycle of a read to addr 0x20 -> the matching response carries rsp_collision=2'b10; neighbouring responses carry 2'b00.
6. Reset mid-stream: assert aresetn low with 2 reads in flight and 2 responses queued -> rsp_valid drops immediately and credits=4. After release, a new read of 0x05 returns only RAM[0x05] with no stale responses.

Source files
------------

// File: rtl/mem_read_port_if.sv
// Request, RAM-side and response signals of one read agent's front-end.
//   slave  : view taken by mem_read_port
//   master : view taken by the read agent / RAM environment
// Signals:
//   req_valid/req_ready/req_addr           read-request handshake
//   rden/rdaddr/rddata/rdcollision         RAM read port
//   rsp_valid/rsp_ready/rsp_data/rsp_collision  response handshake
//   credits                                free response credits (status)
interface mem_read_port_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rden;
  logic [ADDR_WIDTH-1:0] rdaddr;
  logic [DATA_WIDTH-1:0] rddata;
  logic [1:0]            rdcollision;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [1:0]            rsp_collision;
  logic [CW-1:0]         credits;

  modport slave (
    input  req_valid, req_addr, rddata, rdcollision, rsp_ready,
    output req_ready, rden, rdaddr, rsp_valid, rsp_data, rsp_collision, credits
  );

  modport master (
    output req_valid, req_addr, rddata, rdcollision, rsp_ready,
    input  req_ready, rden, rdaddr, rsp_valid, rsp_data, rsp_collision, credits
  );
endinterface

// File: rtl/mem_read_port.sv
// Per-agent read front-end for the multi-port RAM.
// Turns a valid/ready request stream into a registered rden/rdaddr strobe,
// tracks the fixed RAM read latency, and queues {rdcollision, rddata} in a
// first-word fall-through response FIFO. Credits bound the number of
// outstanding reads so a queued response can never be dropped.
// Ports:
//   aclk, aresetn  clock, asynchronous active-low reset
//   bus            mem_read_port_if.slave (request, RAM, response, credits)
module mem_read_port #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic            aclk,
  input logic            aresetn,
  mem_read_port_if.slave bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [1:0]            coll;
    logic [DATA_WIDTH-1:0] data;
  } rsp_entry_t;

  logic                  req_ready_q, req_ready_d;
  logic                  rden_q,      rden_d;
  logic [ADDR_WIDTH-1:0] rdaddr_q,    rdaddr_d;
  logic [RD_LATENCY-1:0] pipe_q,      pipe_d;
  logic [CW-1:0]         credits_q,   credits_d;
  logic [CW-1:0]         count_q,     count_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [PW-1:0]         wr_ptr_q,    wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q,    rd_ptr_d;
  rsp_entry_t            mem_q [FIFO_DEPTH];

  logic accept_c;
  logic pop_c;
  logic push_c;
  logic full_c;

  // Pointer advance with explicit wrap so non-power-of-two depths still work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Latency shift register: pipe[0] follows rden, then one stage per cycle.
  if (RD_LATENCY > 1) begin : g_pipe_shift
    always_comb pipe_d = {pipe_q[RD_LATENCY-2:0], rden_q};
  end else begin : g_pipe_single
    always_comb pipe_d = rden_q;
  end

  // Handshakes, credit accounting and FIFO bookkeeping.
  always_comb begin
    accept_c    = bus.req_valid & req_ready_q;
    pop_c       = rsp_valid_q & bus.rsp_ready;
    push_c      = pipe_q[RD_LATENCY-1];
    full_c      = (count_q == CW'(FIFO_DEPTH));

    rden_d      = accept_c;
    rdaddr_d    = accept_c ? bus.req_addr : rdaddr_q;

    credits_d   = credits_q;
    case ({accept_c, pop_c})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
    // Registered so req_ready has no combinational path from rsp_ready/req_valid.
    req_ready_d = (credits_d != '0);

    count_d     = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    rsp_valid_d = (count_d != '0);

    wr_ptr_d    = push_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop_c  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  // Control state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      req_ready_q <= 1'b0;
      rden_q      <= 1'b0;
      rdaddr_q    <= '0;
      pipe_q      <= '0;
      credits_q   <= CW'(FIFO_DEPTH);
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      req_ready_q <= req_ready_d;
      rden_q      <= rden_d;
      rdaddr_q    <= rdaddr_d;
      pipe_q      <= pipe_d;
      credits_q   <= credits_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Response storage; cleared on reset so an empty head reads as zero.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_c) begin
      mem_q[wr_ptr_q] <= '{coll: bus.rdcollision, data: bus.rddata};
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.rden          = rden_q;
  assign bus.rdaddr        = rdaddr_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = mem_q[rd_ptr_q].data;
  assign bus.rsp_collision = mem_q[rd_ptr_q].coll;
  assign bus.credits       = credits_q;

  // Credits make a full-FIFO push unreachable; catch any breach in simulation.
  a_no_push_when_full : assert property (
    @(posedge aclk) disable iff (!aresetn) !(push_c && full_c)
  ) else $error("mem_read_port: response pushed while FIFO full");

  a_credits_bounded : assert property (
    @(posedge aclk) disable iff (!aresetn) credits_q <= CW'(FIFO_DEPTH)
  ) else $error("mem_read_port: credits above FIFO_DEPTH");

endmodule

// File: tb/tb_mem_read_port.sv
// Self-checking bench for mem_read_port: directed scenarios plus a random
// phase, all checked against a transaction-level model (expected-response
// queue stamped with arrival time, credits = depth - outstanding).
module tb_mem_read_port;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned LAT   = 1;
  localparam int unsigned DEPTH = 4;

  logic aclk = 1'b0;
  logic aresetn;

  always #5 aclk = ~aclk;

  mem_read_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  mem_read_port #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  // RAM model: contents plus per-address collision flags, fixed read latency.
  logic [DW-1:0]   ram      [256];
  logic [1:0]      coll_tab [256];
  logic [DW+1:0]   rpipe    [LAT];

  always @(posedge aclk) begin
    rpipe[0] <= bus.rden ? {coll_tab[bus.rdaddr], ram[bus.rdaddr]}
                         : {2'b11, 32'hBAD0_BAD0};
    for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign bus.rdcollision = rpipe[LAT-1][DW+1:DW];
  assign bus.rddata      = rpipe[LAT-1][DW-1:0];

  // Reference model state.
  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    c;
    int            t;
  } exp_t;

  exp_t          q[$];
  int            credits_m;
  int            cyc;
  int            since_rst;
  logic          exp_rden;
  logic [AW-1:0] exp_rdaddr;
  int            n_obs_pop;

  int n_cmp;
  int n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_valid();
    if (q.size() == 0) return 1'b0;
    return q[0].t <= cyc;
  endfunction

  function automatic bit m_ready();
    return (since_rst >= 1) && (credits_m != 0);
  endfunction

  task automatic check_outputs();
    check("req_ready", 64'(bus.req_ready), 64'(m_ready()));
    check("credits",   64'(bus.credits),   64'(credits_m));
    check("rden",      64'(bus.rden),      64'(exp_rden));
    check("rdaddr",    64'(bus.rdaddr),    64'(exp_rdaddr));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid()));
    if (m_valid()) begin
      check("rsp_data", 64'(bus.rsp_data),      64'(q[0].d));
      check("rsp_coll", 64'(bus.rsp_collision), 64'(q[0].c));
    end
  endtask

  // One clock cycle: called at a negedge with inputs already driven.
  task automatic tick();
    bit            acc;
    bit            pop;
    logic [AW-1:0] a;
    check_outputs();
    acc = bus.req_valid && m_ready();
    pop = bus.rsp_ready && m_valid();
    a   = bus.req_addr;
    if (bus.rsp_valid && bus.rsp_ready) n_obs_pop++;
    @(posedge aclk);
    cyc++;
    since_rst++;
    if (pop) begin
      void'(q.pop_front());
      credits_m++;
    end
    if (acc) begin
      q.push_back('{ram[a], coll_tab[a], cyc + LAT + 1});
      credits_m--;
    end
    exp_rden = acc;
    if (acc) exp_rdaddr = a;
    @(negedge aclk);
  endtask

  task automatic do_reset(input int ncyc);
    aresetn = 1'b0;
    #1;
    q.delete();
    credits_m  = DEPTH;
    exp_rden   = 1'b0;
    exp_rdaddr = '0;
    since_rst  = 0;
    check_outputs();
    check("rst_rsp_data", 64'(bus.rsp_data),      64'd0);
    check("rst_rsp_coll", 64'(bus.rsp_collision), 64'd0);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge aclk);
      check_outputs();
    end
    aresetn   = 1'b1;
    since_rst = 0;
  endtask

  task automatic drain();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) tick();
    check("drain_empty", 64'(q.size()), 64'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int pops0;
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    n_obs_pop = 0;
    for (int i = 0; i < 256; i++) begin
      ram[i]      = $urandom;
      coll_tab[i] = (i >= 64) ? 2'($urandom_range(0, 3)) : 2'b00;
    end
    for (int i = 0; i < 16; i++) ram[i] = 32'(i * 3);
    ram[8'h10]      = 32'hDEAD_BEEF;
    coll_tab[8'h20] = 2'b10;

    bus.req_valid = 1'b1;
    bus.req_addr  = 8'h10;
    bus.rsp_ready = 1'b0;
    aresetn       = 1'b1;
    #2;

    // 1: reset with req_valid held high.
    do_reset(3);
    tick();
    check("rst_first_ready", 64'(bus.req_ready), 64'd1);

    // 2: single read of 0x10.
    bus.req_valid = 1'b1;
    bus.req_addr  = 8'h10;
    tick();
    bus.req_valid = 1'b0;
    check("single_rden",   64'(bus.rden),   64'd1);
    check("single_rdaddr", 64'(bus.rdaddr), 64'h10);
    tick();
    tick();
    check("single_valid", 64'(bus.rsp_valid),     64'd1);
    check("single_data",  64'(bus.rsp_data),      64'hDEAD_BEEF);
    check("single_coll",  64'(bus.rsp_collision), 64'd0);
    drain();

    // 3: 16 back-to-back reads with rsp_ready held high.
    bus.rsp_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 8'(i);
      if (bus.req_ready) n++;
      tick();
    end
    check("stream_accepts", 64'(n), 64'd16);
    drain();

    // 4: back-pressure until credits run out, then a single pop.
    bus.rsp_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.req_ready) break;
      bus.req_valid = 1'b1;
      bus.req_addr  = 8'($urandom_range(0, 255));
      tick();
      n++;
    end
    check("bp_accepted", 64'(n), 64'(DEPTH));
    repeat (3) tick();
    check("bp_credits0", 64'(bus.credits),   64'd0);
    check("bp_ready0",   64'(bus.req_ready), 64'd0);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("bp_credits1", 64'(bus.credits),   64'd1);
    check("bp_ready1",   64'(bus.req_ready), 64'd1);
    drain();

    // 5: collision flags travel with their own read only.
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 8'(8'h1F + i);
      tick();
    end
    drain();

    // 6: reset with two reads in flight and two responses queued.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 8'(8'h30 + i);
      tick();
    end
    bus.req_valid = 1'b0;
    check("pre_rst_valid", 64'(bus.rsp_valid), 64'd1);
    do_reset(2);
    tick();
    pops0 = n_obs_pop;
    bus.req_valid = 1'b1;
    bus.req_addr  = 8'h05;
    tick();
    drain();
    check("post_rst_single_rsp", 64'(n_obs_pop - pops0), 64'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bus.req_valid = ($urandom_range(0, 9) < 7);
      bus.req_addr  = 8'($urandom_range(0, 255));
      bus.rsp_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
